// File: rtl/mem_slice_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_slice_if
// Description : Data-memory request/acknowledge bus between the memory stage
//               of the pipeline and the data memory.
//               master modport : pipeline memory stage (mem_slice)
//               slave  modport : data memory
// Signals     : mem_req   master->slave  request, held until mem_ack
//               mem_we    master->slave  1=write, 0=read (valid with mem_req)
//               mem_addr  master->slave  request address (stable with mem_req)
//               mem_wdata master->slave  store data (stable with mem_req)
//               mem_rdata slave->master  load data, valid with mem_ack
//               mem_ack   slave->master  one-cycle completion pulse
// Revision    : 1.0  initial release
// ============================================================================
interface mem_slice_if #(
   parameter int DW = 16
);
   logic          mem_req;
   logic          mem_we;
   logic [DW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic          mem_ack;

   modport master (
      output mem_req,
      output mem_we,
      output mem_addr,
      output mem_wdata,
      input  mem_rdata,
      input  mem_ack
   );

   modport slave (
      input  mem_req,
      input  mem_we,
      input  mem_addr,
      input  mem_wdata,
      output mem_rdata,
      output mem_ack
   );
endinterface
`default_nettype wire

// File: rtl/mem_slice.sv
`default_nettype none
// ============================================================================
// Module      : mem_slice
// Description : Memory stage of the 5-stage pipeline. Captures the execute
//               stage outputs in the EX/MEM latch, performs the data-memory
//               load/store over a req/ack handshake (stalling upstream while
//               waiting, aborting after TIMEOUT cycles) and drives the
//               registered MEM/WB outputs toward writeback.
// Parameters  : DW       datapath / memory word width
//               TIMEOUT  max ACCESS cycles without mem_ack before abort
// Ports       : clk, rst          clock, synchronous active-low reset
//               in_valid, WB_in, M_in, addr, data, result, flags, rd_in
//                                 execute-stage instruction (M_in[1]=read,
//                                 M_in[0]=write)
//               stall             upstream must hold its outputs
//               mem               data-memory bus (master side)
//               wb_valid, WB, wb_data, wb_rd, flags_out
//                                 MEM/WB register toward writeback
//               mem_err           one-cycle pulse: aborted access / illegal M
// Revision    : 1.0  initial release
// ============================================================================
module mem_slice #(
   parameter int DW      = 16,
   parameter int TIMEOUT = 15
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   input  logic          WB_in,
   input  logic [1:0]    M_in,
   input  logic [DW-1:0] addr,
   input  logic [DW-1:0] data,
   input  logic [DW-1:0] result,
   input  logic [2:0]    flags,
   input  logic [3:0]    rd_in,
   output logic          stall,
   mem_slice_if.master   mem,
   output logic          wb_valid,
   output logic          WB,
   output logic [DW-1:0] wb_data,
   output logic [3:0]    wb_rd,
   output logic [2:0]    flags_out,
   output logic          mem_err
);

   localparam int c_cnt_w = $clog2(TIMEOUT + 1);
   localparam logic [c_cnt_w-1:0] c_timeout_last = c_cnt_w'(TIMEOUT - 1);
   localparam logic [c_cnt_w-1:0] c_cnt_one      = c_cnt_w'(1);

   typedef enum logic [0:0] {
      S_IDLE   = 1'b0,
      S_ACCESS = 1'b1
   } state_t;

   state_t r_state;
   logic [c_cnt_w-1:0] r_count;

   // EX/MEM latch
   logic          r_ex_valid;
   logic          r_ex_wb;
   logic [1:0]    r_ex_m;
   logic [DW-1:0] r_ex_addr;
   logic [DW-1:0] r_ex_data;
   logic [DW-1:0] r_ex_result;
   logic [2:0]    r_ex_flags;
   logic [3:0]    r_ex_rd;

   // MEM/WB register
   logic          r_wb_valid;
   logic          r_wb;
   logic [DW-1:0] r_wb_data;
   logic [3:0]    r_wb_rd;
   logic [2:0]    r_flags_out;
   logic          r_mem_err;

   logic w_access;
   logic w_timeout_hit;
   logic w_mem_op;
   logic w_access_wait;
   logic w_enter_access;
   logic w_ex_load;

   assign w_access       = (r_state == S_ACCESS);
   assign w_timeout_hit  = w_access && (r_count == c_timeout_last);
   assign w_mem_op       = r_ex_valid && ((r_ex_m == 2'b01) || (r_ex_m == 2'b10));
   assign w_access_wait  = w_access && !mem.mem_ack && !w_timeout_hit;
   assign w_enter_access = (r_state == S_IDLE) && w_mem_op;

   // A memory op keeps its payload in the EX/MEM latch for the whole access
   // (it supplies mem_addr/mem_wdata/result/rd), so the latch must not load
   // on the edge that moves it into ACCESS either. Upstream is only asked to
   // hold in that cycle when it actually presents an instruction; a bubble
   // can simply be dropped.
   assign w_ex_load = !(w_access_wait || w_enter_access);
   assign stall     = w_access_wait || (w_enter_access && in_valid);

   // Memory bus is driven only from ACCESS so it is all-zero otherwise.
   assign mem.mem_req   = w_access;
   assign mem.mem_we    = w_access && r_ex_m[0];
   assign mem.mem_addr  = w_access ? r_ex_addr : '0;
   assign mem.mem_wdata = w_access ? r_ex_data : '0;

   assign wb_valid  = r_wb_valid;
   assign WB        = r_wb;
   assign wb_data   = r_wb_data;
   assign wb_rd     = r_wb_rd;
   assign flags_out = r_flags_out;
   assign mem_err   = r_mem_err;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state     <= S_IDLE;
         r_count     <= '0;
         r_ex_valid  <= 1'b0;
         r_ex_wb     <= 1'b0;
         r_ex_m      <= 2'b00;
         r_ex_addr   <= '0;
         r_ex_data   <= '0;
         r_ex_result <= '0;
         r_ex_flags  <= 3'b000;
         r_ex_rd     <= 4'h0;
         r_wb_valid  <= 1'b0;
         r_wb        <= 1'b0;
         r_wb_data   <= '0;
         r_wb_rd     <= 4'h0;
         r_flags_out <= 3'b000;
         r_mem_err   <= 1'b0;
      end else begin
         // Pulses default low; payload holds until the next retire.
         r_wb_valid <= 1'b0;
         r_wb       <= 1'b0;
         r_mem_err  <= 1'b0;

         if (w_ex_load) begin
            r_ex_valid  <= in_valid;
            r_ex_wb     <= WB_in;
            r_ex_m      <= M_in;
            r_ex_addr   <= addr;
            r_ex_data   <= data;
            r_ex_result <= result;
            r_ex_flags  <= flags;
            r_ex_rd     <= rd_in;
         end

         case (r_state)
            S_IDLE: begin
               r_count <= '0;
               if (r_ex_valid) begin
                  case (r_ex_m)
                     2'b00: begin
                        r_wb_valid  <= 1'b1;
                        r_wb        <= r_ex_wb;
                        r_wb_data   <= r_ex_result;
                        r_wb_rd     <= r_ex_rd;
                        r_flags_out <= r_ex_flags;
                     end
                     2'b11: begin
                        // Illegal encoding: retire without a register write.
                        r_wb_valid  <= 1'b1;
                        r_wb        <= 1'b0;
                        r_wb_data   <= r_ex_result;
                        r_wb_rd     <= r_ex_rd;
                        r_flags_out <= r_ex_flags;
                        r_mem_err   <= 1'b1;
                     end
                     default: begin
                        r_state <= S_ACCESS;
                     end
                  endcase
               end
            end

            S_ACCESS: begin
               if (mem.mem_ack) begin
                  r_wb_valid  <= 1'b1;
                  r_wb        <= r_ex_wb;
                  r_wb_data   <= r_ex_m[1] ? mem.mem_rdata : r_ex_result;
                  r_wb_rd     <= r_ex_rd;
                  r_flags_out <= r_ex_flags;
                  r_count     <= '0;
                  r_state     <= S_IDLE;
               end else if (w_timeout_hit) begin
                  // Abort: retire without a register write and flag it.
                  r_wb_valid  <= 1'b1;
                  r_wb        <= 1'b0;
                  r_wb_data   <= r_ex_result;
                  r_wb_rd     <= r_ex_rd;
                  r_flags_out <= r_ex_flags;
                  r_mem_err   <= 1'b1;
                  r_count     <= '0;
                  r_state     <= S_IDLE;
               end else begin
                  r_count <= r_count + c_cnt_one;
               end
            end

            default: begin
               r_state <= S_IDLE;
               r_count <= '0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
